// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Bus-mapped 8N1 UART transmitter with a small byte FIFO and a
//             programmable bit period (DATA / STATUS / DIV registers).
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output logic [31:0] o_q,
  output logic        o_tx
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_AW:0]   r_count;
  logic            r_overrun;
  logic [15:0]     r_div;
  logic [15:0]     r_baud;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_idx;
  state_t          r_state;
  logic            r_tx;
  logic [31:0]     r_q;

  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_bit_end;
  logic        w_ovr_clr;
  logic [15:0] w_reload;
  logic        w_unused;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_FULL);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = i_we && (i_addr[1:0] == 2'd0) && i_be[0];
  assign w_push     = w_push_req && !w_full;
  assign w_bit_end  = (r_baud == 16'd0);
  assign w_pop      = !w_empty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign w_ovr_clr  = i_we && (i_addr[1:0] == 2'd1) && i_be[0] && i_wdata[3];
  // A zero divider behaves as one cycle per bit.
  assign w_reload   = (r_div == 16'd0) ? 16'd0 : (r_div - 16'd1);
  assign w_unused   = ^{i_addr[7:2], i_wdata[31:16], i_be[3:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_div     <= DEFAULT_DIV;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_wdata[7:0];
        r_wptr        <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (c_AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (c_AW + 1)'(1);
      end
      // A dropped push outranks a simultaneous clear so no loss goes unreported.
      if (w_push_req && w_full) begin
        r_overrun <= 1'b1;
      end else if (w_ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (i_we && (i_addr[1:0] == 2'd2)) begin
        if (i_be[0]) r_div[7:0]  <= i_wdata[7:0];
        if (i_be[1]) r_div[15:8] <= i_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= 16'd0;
      r_shift   <= 8'd0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= w_reload;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= 3'd0;
            r_baud    <= w_reload;
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud <= w_reload;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            // Chain straight into the next start bit when data is waiting.
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_baud  <= w_reload;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 32'd0;
    end else begin
      case (i_addr[1:0])
        2'd1:    r_q <= {28'd0, r_overrun, w_busy, w_full, w_empty};
        2'd2:    r_q <= {16'd0, r_div};
        default: r_q <= 32'd0;
      endcase
    end
  end

  assign o_q  = r_q;
  assign o_tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Randomised and directed bench for uart_tx with a bit-level
//             reference model and a serial-frame scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr = 8'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        we = 1'b0;
  logic [31:0] q;
  logic        tx;

  uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .i_addr(addr), .i_be(be), .i_wdata(wdata),
    .i_we(we), .o_q(q), .o_tx(tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents plus the frame in flight, tracked as
  // "bits left in frame" and "cycles left in current bit".
  logic [7:0]  m_fifo[$];
  logic        m_over = 1'b0;
  logic [15:0] m_div = 16'd434;
  logic        m_busy = 1'b0;
  int          m_bits_left = 0;
  int          m_bit_cyc = 0;
  logic [7:0]  m_cur = 8'd0;
  logic [31:0] q_exp = 32'd0;
  logic        tx_exp = 1'b1;

  // Scoreboard of bytes expected on the serial line.
  logic [7:0]  exp_bytes[$];
  logic        mon_en = 1'b0;
  int          mon_div = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [15:0] d);
    return (d == 16'd0) ? 1 : int'(d);
  endfunction

  task automatic model_edge();
    logic full_pre;
    logic empty_pre;
    int   idx;
    if (rst) begin
      m_fifo.delete();
      m_over = 1'b0; m_div = 16'd434; m_busy = 1'b0;
      m_bits_left = 0; m_bit_cyc = 0;
      q_exp = 32'd0; tx_exp = 1'b1;
      return;
    end
    full_pre  = (m_fifo.size() == DEPTH);
    empty_pre = (m_fifo.size() == 0);
    case (addr[1:0])
      2'd1:    q_exp = {28'd0, m_over, m_busy, full_pre, empty_pre};
      2'd2:    q_exp = {16'd0, m_div};
      default: q_exp = 32'd0;
    endcase
    if (m_busy) begin
      if (m_bit_cyc > 1) m_bit_cyc--;
      else begin
        m_bits_left--;
        if (m_bits_left == 0) m_busy = 1'b0;
        else m_bit_cyc = eff(m_div);
      end
    end
    if (!m_busy && !empty_pre) begin
      m_cur = m_fifo.pop_front();
      m_busy = 1'b1; m_bits_left = 10; m_bit_cyc = eff(m_div);
    end
    if (we && addr[1:0] == 2'd0 && be[0]) begin
      if (full_pre) m_over = 1'b1;
      else begin
        m_fifo.push_back(wdata[7:0]);
        if (mon_en) exp_bytes.push_back(wdata[7:0]);
      end
    end else if (we && addr[1:0] == 2'd1 && be[0] && wdata[3]) begin
      m_over = 1'b0;
    end
    if (we && addr[1:0] == 2'd2) begin
      if (be[0]) m_div[7:0]  = wdata[7:0];
      if (be[1]) m_div[15:8] = wdata[15:8];
    end
    if (!m_busy) tx_exp = 1'b1;
    else begin
      idx = 10 - m_bits_left;
      if (idx == 0) tx_exp = 1'b0;
      else if (idx == 9) tx_exp = 1'b1;
      else tx_exp = m_cur[idx-1];
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("q_cycle", q, q_exp);
    check("tx_cycle", {31'd0, tx}, {31'd0, tx_exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
    addr = a; be = b; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    addr = a; we = 1'b0;
    step();
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((m_fifo.size() != 0 || m_busy) && n < maxc) begin
      rd(8'd1);
      n++;
    end
    check("drain_done", {31'd0, m_busy}, 32'd0);
    rd(8'd0); rd(8'd0);
  endtask

  // Serial monitor: decode each frame at mid-bit and compare with the scoreboard.
  initial begin
    logic       act;
    int         k;
    int         d;
    int         b;
    logic [7:0] sh;
    logic       startb;
    logic       stopb;
    logic [7:0] e;
    act = 1'b0; k = 0; d = 1; sh = 8'd0; startb = 1'b1; stopb = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        act = 1'b0;
      end else begin
        if (!act) begin
          if (tx === 1'b0) begin
            act = 1'b1; k = 0; d = mon_div; sh = 8'd0;
          end
        end else begin
          k++;
        end
        if (act) begin
          b = k / d;
          if ((k % d) == d / 2) begin
            if (b == 0) startb = tx;
            else if (b <= 8) sh[b-1] = tx;
            else stopb = tx;
          end
          if (k == 10 * d - 1) begin
            act = 1'b0;
            if (exp_bytes.size() == 0) begin
              total++; bad++;
              $display("FAIL rx_unexpected: got frame 0x%0h expected none", sh);
            end else begin
              e = exp_bytes.pop_front();
              check("rx_frame", {22'd0, stopb, sh, startb}, {22'd0, 1'b1, e, 1'b0});
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [7:0] a;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_q", q, 32'd0);
    rd(8'd1); check("status_reset", q, 32'h1);
    rd(8'd2); check("div_reset", q, 32'd434);
    for (int i = 0; i < 100; i++) rd(8'd0);

    // Single frame at four cycles per bit.
    mon_en = 1'b1; mon_div = 4;
    wr(8'd2, 4'b0011, 32'd4);
    wr(8'd0, 4'b0001, 32'h55);
    check("tx_idle_at_write", {31'd0, tx}, 32'd1);
    rd(8'd1);
    check("tx_start_low", {31'd0, tx}, 32'd0);
    drain(100);
    rd(8'd1); check("status_after_frame", q, 32'h1);

    // Six consecutive pushes into a four-deep FIFO.
    for (int i = 1; i <= 6; i++) wr(8'd0, 4'b0001, 32'(i));
    rd(8'd1); check("overrun_set", {31'd0, q[3]}, 32'd1);
    wr(8'd1, 4'b0001, 32'h8);
    rd(8'd1); check("overrun_clear", {31'd0, q[3]}, 32'd0);
    drain(300);

    // Divider change mid-frame, during data bit 2.
    mon_en = 1'b0;
    wr(8'd0, 4'b0001, 32'hA3);
    for (int i = 0; i < 13; i++) rd(8'd0);
    wr(8'd2, 4'b0011, 32'd8);
    drain(200);

    // Reset in the middle of data bit 4 with a second byte queued.
    wr(8'd2, 4'b0011, 32'd4);
    wr(8'd0, 4'b0001, 32'h3C);
    wr(8'd0, 4'b0001, 32'h5A);
    for (int i = 0; i < 20; i++) rd(8'd0);
    rst = 1'b1; step(); rst = 1'b0;
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    rd(8'd1); check("status_after_reset", q, 32'h1);
    rd(8'd2); check("div_after_reset", q, 32'd434);
    for (int i = 0; i < 60; i++) rd(8'd1);
    exp_bytes.delete();

    // Byte-enabled divider write, then DIV=0.
    wr(8'd6, 4'b0010, 32'h0000AB00);
    rd(8'd2); check("div_byte_enable", q, 32'hABB2);
    mon_en = 1'b1; mon_div = 1;
    wr(8'd2, 4'b0011, 32'd0);
    wr(8'd0, 4'b0001, 32'hFF);
    drain(50);

    // Randomised traffic with the divider held fixed.
    r = $urandom_range(1, 3);
    mon_div = r;
    wr(8'd2, 4'b0011, 32'(r));
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 63)) << 2;
      if (r <= 4)      wr(a, 4'($urandom_range(0, 15)), $urandom);
      else if (r == 5) wr(a | 8'd1, 4'($urandom_range(0, 15)), $urandom);
      else if (r == 6) wr(a | 8'd3, 4'hF, $urandom);
      else             rd(a | 8'($urandom_range(0, 3)));
    end
    drain(400);
    check("scoreboard_empty", exp_bytes.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Memory-mapped UART transmitter peripheral that sits on the core data bus beside the GPIO block, downstream of `bus_interconnect`. It receives the same word address, byte enables, write data and decoded write-enable that GPIO receives, and returns its read data to the interconnect. Written bytes are buffered in a small FIFO and serialized as 8N1 frames on `tx` at a programmable bit period.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `DEFAULT_DIV`, 16'd434: reset value of the bit-period register, in clock cycles per bit.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `addr`  in  8  word address (bus `addr[9:2]`); `addr[1:0]` selects the register and the upper bits are ignored.
- `be`  in  4  byte enables for writes.
- `wdata`  in  32  write data.
- `we`  in  1  write strobe, already decoded for this peripheral.
- `q`  out  32  registered read data.
- `tx`  out  1  serial output; idle high.

## Operation
- Register map, selected by `addr[1:0]`:
  - 0 DATA (write only): a write with `be[0]=1` pushes `wdata[7:0]` into the FIFO. Reads of this register return 0.
  - 1 STATUS: bit0 empty, bit1 full, bit2 busy (FSM not IDLE), bit3 overrun (sticky). All other bits read 0. A write with `be[0]=1` and `wdata[3]=1` clears overrun. Other bits ignore writes.
  - 2 DIV: bits[15:0] hold the bit period. Writes are byte-enabled through `be[1:0]`. Bits[31:16] read 0.
  - 3: reserved; reads return 0 and writes are ignored.
- Push rules:
  - Fullness is judged on the pre-edge count.
  - A push to a full FIFO is dropped and sets overrun, even if a pop occurs on the same edge.
  - Push and pop on the same edge when not full leave the count unchanged.
- Transmit FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx=0` for one bit period, then go to DATA.
  - DATA: shift out 8 bits LSB first, one bit period each, using a 3-bit bit index. After bit 7, go to STOP.
  - STOP: `tx=1` for one bit period. On its last cycle, if the FIFO is non-empty, pop and go directly to START, so there is no idle gap. Otherwise go to IDLE.
- Bit period: the baud counter reloads with `DIV-1` at each bit start and counts down to 0. A bit lasts `DIV` cycles. `DIV=0` is treated as 1.
- A DIV write during a frame takes effect at the next bit boundary. The bit in progress keeps its length.
- `q` updates every cycle from the register selected by `addr`, regardless of `we`.

## Timing
- Reset values: `tx=1`, `q=0`, FIFO empty, overrun=0, FSM=IDLE, DIV=`DEFAULT_DIV`, baud counter=0, shift register=0.
- Reset mid-frame: `tx` is 1 from the edge where `rst` is sampled high. The FIFO is flushed and DIV returns to its default. No partial frame resumes.
- Read latency: 1 cycle. `addr` sampled at edge N produces `q` valid after edge N, with STATUS reflecting pre-edge-N state.
- Transmit latency from an idle, empty FIFO:
  - Push at edge N makes the FIFO non-empty after N.
  - The FSM pops at edge N+1, and `tx` goes low after N+1.
- Frame length: exactly `10*DIV` cycles. Back-to-back frames are contiguous.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- busy is 1 from the pop edge until the STOP→IDLE edge.

## Test plan
- Reset, then read STATUS and DIV: STATUS=0x1 and DIV=434. `tx` stays 1 for 100 cycles.
- Set DIV=4, write DATA=0x55:
  - `tx` goes low 1 cycle after the write edge.
  - The bit sequence is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total.
  - After the frame, busy=0 and empty=1.
- Set DIV=4, write bytes 0x01..0x06 on 6 consecutive cycles (DEPTH=4):
  - 0x01..0x05 are transmitted back-to-back with no idle cycles, 200 cycles.
  - 0x06 is dropped and overrun=1.
  - Writing STATUS with `wdata=0x8` clears overrun.
- Set DIV=4, queue 0xA3, and write DIV=8 during data bit 2: bits 0-2 last 4 cycles each and all later bits last 8 cycles.
- Assert `rst` for 1 cycle during data bit 4 of a frame with 2 bytes queued:
  - `tx`=1 on the next cycle.
  - STATUS=0x1 and DIV=434.
  - No further frame is transmitted.
- Write DIV=0 then DATA=0xFF: each bit lasts 1 cycle, giving a 10-cycle frame (start low, then 9 high).
